bp_cce_ucode_loader: RTL and testbench
======================================

BP_CCE_UCODE_LOADER -- requirements
Module: bp_cce_ucode_loader

Interface
REQ-001 Parameter: pc_width_p, default 8, CCE microcode PC/address width.
REQ-002 Parameter: instr_width_p, default 64, microcode instruction width.
REQ-003 Parameter: verify_p, default 1, 1 = read back and compare each written instruction, 0 = write only.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  reset; synchronous and active-high.
REQ-006 start_i  input  1  load request; sampled only in IDLE or DONE.
REQ-007 num_instr_i  input  pc_width_p+1  instruction count; captured on the accepted start.
REQ-008 instr_i  input  instr_width_p  next instruction from the source stream.
REQ-009 instr_v_i  input  1  instruction valid.
REQ-010 instr_ready_and_o  output  1  loader accepts instr_i this cycle.
REQ-011 ucode_v_o  output  1  ucode RAM access strobe.
REQ-012 ucode_w_o  output  1  1 = write, 0 = read.
REQ-013 ucode_addr_o  output  pc_width_p  ucode RAM address.
REQ-014 ucode_data_o  output  instr_width_p  ucode RAM write data.
REQ-015 ucode_data_i  input  instr_width_p  ucode RAM read data, valid the cycle after a read strobe.
REQ-016 busy_o  output  1  load in progress.
REQ-017 done_o  output  1  load finished, with or without error.
REQ-018 error_o  output  1  readback mismatch detected.
REQ-019 error_addr_o  output  pc_width_p  address of the first mismatch.

Function
REQ-020 States SHALL be IDLE, WRITE, READ, CHECK and DONE.
REQ-021 IDLE or DONE with start_i=1: latch min(num_instr_i, 2^pc_width_p); clear addr counter, error_o, error_addr_o and done_o; go to WRITE, or to DONE if the count is 0.
REQ-022 start_i in WRITE, READ or CHECK SHALL be ignored.
REQ-023 WRITE: instr_ready_and_o=1.
REQ-024 WRITE: on instr_v_i=1, drive ucode_v_o=1, ucode_w_o=1, ucode_addr_o=addr, ucode_data_o=instr_i in the same cycle, and capture instr_i into a hold register.
REQ-025 WRITE with instr_v_i=0: ucode_v_o=0; stay in WRITE.
REQ-026 After a WRITE handshake with verify_p=1: go to READ.
REQ-027 After a WRITE handshake with verify_p=0: addr+1, then DONE if addr+1 equals the count, else stay in WRITE.
REQ-028 READ: ucode_v_o=1, ucode_w_o=0, ucode_addr_o=addr, instr_ready_and_o=0; go to CHECK after 1 cycle.
REQ-029 CHECK: compare ucode_data_i with the hold register; ucode_v_o=0, instr_ready_and_o=0.
REQ-030 CHECK mismatch: set error_o=1, error_addr_o=addr; go to DONE (abort, remaining instructions not consumed).
REQ-031 CHECK match: addr+1, then DONE if addr+1 equals the count, else WRITE.
REQ-032 Throughput: 1 instruction/cycle with verify_p=0; 1 instruction per 3 cycles with verify_p=1 and instr_v_i held high.
REQ-033 addr counter SHALL be pc_width_p+1 bits; ucode_addr_o = low pc_width_p bits, so count 2^pc_width_p writes addresses 0..2^pc_width_p-1 with no wrap.
REQ-034 busy_o=1 in WRITE, READ and CHECK.
REQ-035 done_o=1 in DONE and holds until the next accepted start or reset.
REQ-036 error_o and error_addr_o SHALL be sticky until the next accepted start or reset.
REQ-037 In every state other than WRITE, READ and CHECK: ucode_v_o=0, ucode_w_o=0.

Reset
REQ-038 reset_i=1 SHALL force IDLE on the next edge from any state, including mid-load.
REQ-039 While reset_i=1: instr_ready_and_o, ucode_v_o, ucode_w_o, busy_o, done_o and error_o = 0.
REQ-040 While reset_i=1: ucode_addr_o=0, error_addr_o=0, ucode_data_o=0.
REQ-041 Reset SHALL NOT issue any RAM access; a load interrupted by reset is not resumed.

Verification
REQ-042 verify_p=1, count=4, source streams 0xA0..0xA3, RAM model correct -> writes then reads addr 0..3, done_o=1 after 12 cycles, error_o=0.
REQ-043 verify_p=1, count=3, RAM model corrupts addr 1 readback -> error_o=1, error_addr_o=1, done_o=1, third instruction not accepted (instr_ready_and_o stays 0).
REQ-044 verify_p=0, count=256, pc_width_p=8, instr_v_i constant -> 256 consecutive writes, addr 0..255, done_o after 256 handshakes; count 300 clamps to 256.
REQ-045 count=0 -> done_o=1 the cycle after start, no ucode_v_o pulse; start_i pulsed while busy_o=1 -> ignored, count unchanged.
REQ-046 instr_v_i toggling 1,0,0,1 in WRITE -> ucode_v_o only on the valid cycles, addresses contiguous.
REQ-047 reset_i asserted in READ -> next cycle IDLE with all outputs zero; a new start then reloads from addr 0.

Source files
------------

// File: rtl/bp_cce_ucode_loader.sv
// CCE microcode loader: streams instructions into the ucode RAM and can
// optionally read each one back to confirm it landed correctly.
module bp_cce_ucode_loader #(
  parameter int pc_width_p    = 8,
  parameter int instr_width_p = 64,
  parameter int verify_p      = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [pc_width_p:0]      num_instr_i,
  input  logic [instr_width_p-1:0] instr_i,
  input  logic                     instr_v_i,
  output logic                     instr_ready_and_o,
  output logic                     ucode_v_o,
  output logic                     ucode_w_o,
  output logic [pc_width_p-1:0]    ucode_addr_o,
  output logic [instr_width_p-1:0] ucode_data_o,
  input  logic [instr_width_p-1:0] ucode_data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [pc_width_p-1:0]    error_addr_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  // A full RAM is 2^pc_width_p entries; the counter is one bit wider so
  // that this count is representable and the last address never wraps.
  localparam logic [pc_width_p:0] max_count_lp = {1'b1, {pc_width_p{1'b0}}};

  state_e                   state_q, state_d;
  logic [pc_width_p:0]      count_q, count_d;
  logic [pc_width_p:0]      addr_q, addr_d;
  logic [instr_width_p-1:0] hold_q, hold_d;
  logic                     error_q, error_d;
  logic [pc_width_p-1:0]    error_addr_q, error_addr_d;

  logic [pc_width_p:0]      addr_inc;
  logic [pc_width_p:0]      start_count;

  assign addr_inc    = addr_q + 1'b1;
  // Any request with the top bit set is at least a full RAM, so clamp it.
  assign start_count = num_instr_i[pc_width_p] ? max_count_lp : num_instr_i;

  // Next-state logic and all outputs; outputs are forced quiet during reset.
  always_comb begin
    state_d           = state_q;
    count_d           = count_q;
    addr_d            = addr_q;
    hold_d            = hold_q;
    error_d           = error_q;
    error_addr_d      = error_addr_q;
    instr_ready_and_o = 1'b0;
    ucode_v_o         = 1'b0;
    ucode_w_o         = 1'b0;
    ucode_addr_o      = '0;
    ucode_data_o      = '0;
    busy_o            = 1'b0;
    done_o            = 1'b0;
    error_o           = 1'b0;
    error_addr_o      = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          count_d      = start_count;
          addr_d       = '0;
          error_d      = 1'b0;
          error_addr_d = '0;
          state_d      = (start_count == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (instr_v_i) begin
          hold_d = instr_i;
          if (verify_p != 0) begin
            state_d = READ;
          end else begin
            addr_d  = addr_inc;
            state_d = (addr_inc == count_q) ? DONE : WRITE;
          end
        end
      end
      READ: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (ucode_data_i != hold_q) begin
          error_d      = 1'b1;
          error_addr_d = addr_q[pc_width_p-1:0];
          state_d      = DONE;
        end else begin
          addr_d  = addr_inc;
          state_d = (addr_inc == count_q) ? DONE : WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!reset_i) begin
      error_o      = error_q;
      error_addr_o = error_addr_q;
      case (state_q)
        WRITE: begin
          instr_ready_and_o = 1'b1;
          ucode_v_o         = instr_v_i;
          ucode_w_o         = instr_v_i;
          ucode_addr_o      = addr_q[pc_width_p-1:0];
          ucode_data_o      = instr_i;
          busy_o            = 1'b1;
        end
        READ: begin
          ucode_v_o    = 1'b1;
          ucode_addr_o = addr_q[pc_width_p-1:0];
          busy_o       = 1'b1;
        end
        CHECK: begin
          busy_o = 1'b1;
        end
        DONE: begin
          done_o = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State register; reset abandons any load in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      count_q      <= '0;
      addr_q       <= '0;
      hold_q       <= '0;
      error_q      <= 1'b0;
      error_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      error_q      <= error_d;
      error_addr_q <= error_addr_d;
    end
  end

endmodule

// File: tb/tb_bp_cce_ucode_loader.sv
// Directed bench for the ucode loader: one instance with readback verify,
// one write-only instance, each with its own small RAM and source stream.
module tb_bp_cce_ucode_loader;

  logic clk = 1'b0;
  logic reset;

  // Verifying instance signals
  logic        startV;
  logic [8:0]  numV;
  logic [63:0] instrV;
  logic        vV;
  logic        readyV, ucodeVV, ucodeWV, busyV, doneV, errorV;
  logic [7:0]  addrV, errAddrV;
  logic [63:0] dataV;
  logic [63:0] rdataV = '0;

  // Write-only instance signals
  logic        startW;
  logic [8:0]  numW;
  logic [63:0] instrW;
  logic        vW;
  logic        readyW, ucodeVW, ucodeWW, busyW, doneW, errorW;
  logic [7:0]  addrW, errAddrW;
  logic [63:0] dataW;
  logic [63:0] rdataW = '0;

  logic [63:0] memV [256];
  logic [63:0] memW [256];
  logic [8:0]  logV[$];
  logic [7:0]  logW[$];
  int          idxV = 0;
  int          idxW = 0;
  int          baseV = 0;
  int          baseW = 0;
  int          corruptAddr = -1;

  int checks = 0;
  int errors = 0;

  assign instrV = 64'hA0 + 64'(idxV - baseV);
  assign instrW = 64'h1000 + 64'(idxW - baseW);

  bp_cce_ucode_loader #(.pc_width_p(8), .instr_width_p(64), .verify_p(1)) dutV (
    .clk_i(clk), .reset_i(reset), .start_i(startV), .num_instr_i(numV),
    .instr_i(instrV), .instr_v_i(vV), .instr_ready_and_o(readyV),
    .ucode_v_o(ucodeVV), .ucode_w_o(ucodeWV), .ucode_addr_o(addrV),
    .ucode_data_o(dataV), .ucode_data_i(rdataV), .busy_o(busyV),
    .done_o(doneV), .error_o(errorV), .error_addr_o(errAddrV)
  );

  bp_cce_ucode_loader #(.pc_width_p(8), .instr_width_p(64), .verify_p(0)) dutW (
    .clk_i(clk), .reset_i(reset), .start_i(startW), .num_instr_i(numW),
    .instr_i(instrW), .instr_v_i(vW), .instr_ready_and_o(readyW),
    .ucode_v_o(ucodeVW), .ucode_w_o(ucodeWW), .ucode_addr_o(addrW),
    .ucode_data_o(dataW), .ucode_data_i(rdataW), .busy_o(busyW),
    .done_o(doneW), .error_o(errorW), .error_addr_o(errAddrW)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // RAM, access log and source stream for the verifying instance; one
  // address can be made to read back corrupted.
  always @(posedge clk) begin
    if (ucodeVV && ucodeWV) memV[addrV] <= dataV;
    if (ucodeVV && !ucodeWV)
      rdataV <= (int'(addrV) == corruptAddr) ? (memV[addrV] ^ 64'hFF) : memV[addrV];
    if (ucodeVV) logV.push_back({ucodeWV, addrV});
    if (readyV && vV) idxV <= idxV + 1;
  end

  // RAM, write-address log and source stream for the write-only instance
  always @(posedge clk) begin
    if (ucodeVW && ucodeWW) memW[addrW] <= dataW;
    if (ucodeVW) logW.push_back(addrW);
    if (readyW && vW) idxW <= idxW + 1;
  end

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Pulse start on one instance at a falling edge; returns one cycle later.
  task automatic applyStimulus(input bit onV, input logic [8:0] n);
    if (onV) begin startV = 1'b1; numV = n; end
    else     begin startW = 1'b1; numW = n; end
    @(negedge clk);
    startV = 1'b0;
    startW = 1'b0;
  endtask

  task automatic waitDoneV(input int limit, output int busyCycles);
    int n;
    n = 0;
    busyCycles = 0;
    while (!doneV && n < limit) begin
      if (busyV) busyCycles++;
      @(negedge clk);
      n++;
    end
    checkOutput("doneV reached", doneV, 1);
  endtask

  task automatic waitDoneW(input int limit, output int busyCycles);
    int n;
    n = 0;
    busyCycles = 0;
    while (!doneW && n < limit) begin
      if (busyW) busyCycles++;
      @(negedge clk);
      n++;
    end
    checkOutput("doneW reached", doneW, 1);
  endtask

  // Main directed sequence
  initial begin
    int busyCyc;
    int logStart;
    int logMark;
    int bad;
    int n;
    logic [8:0] expEntry;
    logic [5:0] pat;

    reset = 1'b1; startV = 1'b0; startW = 1'b0;
    numV = '0; numW = '0; vV = 1'b0; vW = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst ready", readyV, 0);
    checkOutput("rst ucode_v", ucodeVV, 0);
    checkOutput("rst ucode_w", ucodeWV, 0);
    checkOutput("rst busy", busyV, 0);
    checkOutput("rst done", doneV, 0);
    checkOutput("rst error", errorV, 0);
    checkOutput("rst addr", addrV, 0);
    checkOutput("rst err addr", errAddrV, 0);
    checkOutput("rst data", dataV, 0);
    checkOutput("rst busyW", busyW, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Verified load of four instructions with a correct RAM
    $display("[TB] verified load, count 4");
    baseV = idxV; logStart = logV.size(); vV = 1'b1;
    applyStimulus(1'b1, 9'd4);
    waitDoneV(60, busyCyc);
    checkOutput("v4 busy cycles", busyCyc, 12);
    checkOutput("v4 error", errorV, 0);
    checkOutput("v4 access count", logV.size() - logStart, 8);
    for (int i = 0; i < 8; i++) begin
      expEntry = {((i % 2) == 0) ? 1'b1 : 1'b0, 8'(i / 2)};
      if (logStart + i < logV.size())
        checkOutput("v4 access", logV[logStart + i], expEntry);
    end
    checkOutput("v4 mem3", memV[3], 64'hA3);

    // Corrupted readback at address 1 aborts the load
    $display("[TB] verified load, count 3, bad readback at 1");
    corruptAddr = 1; baseV = idxV; logStart = logV.size();
    applyStimulus(1'b1, 9'd3);
    waitDoneV(60, busyCyc);
    checkOutput("bad busy cycles", busyCyc, 6);
    checkOutput("bad error", errorV, 1);
    checkOutput("bad err addr", errAddrV, 1);
    checkOutput("bad accepted", idxV - baseV, 2);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (readyV) bad++;
    end
    checkOutput("bad ready after abort", bad, 0);
    checkOutput("bad accepted later", idxV - baseV, 2);
    checkOutput("bad error sticky", errorV, 1);
    checkOutput("bad done held", doneV, 1);
    checkOutput("bad access count", logV.size() - logStart, 4);
    corruptAddr = -1;

    // Zero count finishes at once and clears the old error
    $display("[TB] zero count");
    logStart = logV.size();
    applyStimulus(1'b1, 9'd0);
    #1;
    checkOutput("zero done", doneV, 1);
    checkOutput("zero busy", busyV, 0);
    checkOutput("zero error cleared", errorV, 0);
    checkOutput("zero err addr cleared", errAddrV, 0);
    checkOutput("zero no access", logV.size() - logStart, 0);

    // Start while busy is ignored
    $display("[TB] start while busy");
    baseV = idxV; logStart = logV.size();
    applyStimulus(1'b1, 9'd2);
    startV = 1'b1; numV = 9'd5;
    repeat (3) @(negedge clk);
    startV = 1'b0;
    waitDoneV(60, busyCyc);
    checkOutput("busy start accesses", logV.size() - logStart, 4);
    checkOutput("busy start accepted", idxV - baseV, 2);
    vV = 1'b0;

    // Write-only full RAM load, then an oversized count
    $display("[TB] write-only load, count 256");
    vW = 1'b1; baseW = idxW; logStart = logW.size();
    applyStimulus(1'b0, 9'd256);
    waitDoneW(600, busyCyc);
    checkOutput("w256 busy cycles", busyCyc, 256);
    checkOutput("w256 writes", logW.size() - logStart, 256);
    bad = 0;
    for (int i = logStart; i < logW.size(); i++)
      if (logW[i] != 8'(i - logStart)) bad++;
    checkOutput("w256 contiguous", bad, 0);
    checkOutput("w256 mem0", memW[0], 64'h1000);
    checkOutput("w256 mem255", memW[255], 64'h10FF);

    $display("[TB] write-only load, count 300");
    baseW = idxW; logStart = logW.size();
    applyStimulus(1'b0, 9'd300);
    waitDoneW(600, busyCyc);
    checkOutput("w300 busy cycles", busyCyc, 256);
    checkOutput("w300 writes", logW.size() - logStart, 256);

    // Gappy valid: strobes only on valid cycles, addresses contiguous
    $display("[TB] toggling valid");
    vW = 1'b0; baseW = idxW; logStart = logW.size();
    applyStimulus(1'b0, 9'd4);
    pat = 6'b111001;
    for (int i = 0; i < 6; i++) begin
      vW = pat[i];
      #1;
      checkOutput("toggle strobe", ucodeVW, pat[i]);
      @(negedge clk);
    end
    vW = 1'b0;
    #1;
    checkOutput("toggle done", doneW, 1);
    checkOutput("toggle writes", logW.size() - logStart, 4);
    bad = 0;
    for (int i = logStart; i < logW.size(); i++)
      if (logW[i] != 8'(i - logStart)) bad++;
    checkOutput("toggle contiguous", bad, 0);
    checkOutput("toggle mem3", memW[3], 64'h1003);

    // Reset during READ, then a fresh load starting at address 0
    $display("[TB] reset during read");
    vV = 1'b1; baseV = idxV;
    applyStimulus(1'b1, 9'd4);
    n = 0;
    while (!(ucodeVV && !ucodeWV) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached read", ucodeVV && !ucodeWV, 1);
    reset = 1'b1;
    #1;
    logMark = logV.size();
    checkOutput("mid rst ucode_v", ucodeVV, 0);
    checkOutput("mid rst busy", busyV, 0);
    checkOutput("mid rst ready", readyV, 0);
    checkOutput("mid rst addr", addrV, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post rst busy", busyV, 0);
    checkOutput("post rst done", doneV, 0);
    checkOutput("post rst error", errorV, 0);
    checkOutput("rst no access", logV.size() - logMark, 0);
    baseV = idxV; logStart = logV.size();
    applyStimulus(1'b1, 9'd1);
    waitDoneV(20, busyCyc);
    checkOutput("reload accesses", logV.size() - logStart, 2);
    if (logStart < logV.size())
      checkOutput("reload first write", logV[logStart], 9'h100);
    checkOutput("reload error", errorV, 0);
    vV = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
